// File: rtl/aes_pkg.sv
// Shared AES definitions for the byte-serial decryptor: FSM states, S-boxes,
// Rcon table and GF(2^8) helpers for the inverse round.
package aes_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_KEYEXP, ST_DEC, ST_OUT} aes_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Padded to 16 entries so a 4-bit round counter can index it directly.
  localparam logic [0:15][7:0] RCON = 128'h01020408102040801b36000000000000;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte i of the state sits at bits 127-8i; byte 4c+r is row r of column c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
            gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
            gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
            gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-schedule step; i_inv selects the inverse
// direction (round key r -> r-1) instead of the forward one (r -> r+1).
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  input  logic         i_inv,
  output logic [127:0] o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_t, w_g;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;
  // Inverse step recovers the previous w3 as w3^w2 before applying the g function.
  assign w_t = i_inv ? (w_w3 ^ w_w2) : w_w3;
  assign w_g = sub_word({w_t[23:0], w_t[31:24]}) ^ {i_rcon, 24'h000000};

  always_comb begin
    w_n0 = w_w0 ^ w_g;
    w_n1 = w_w1 ^ w_n0;
    w_n2 = w_w2 ^ w_n1;
    w_n3 = w_w3 ^ w_n2;
    if (i_inv) begin
      w_n3 = w_w3 ^ w_w2;
      w_n2 = w_w2 ^ w_w1;
      w_n1 = w_w1 ^ w_w0;
      w_n0 = w_w0 ^ w_g;
    end
  end

  assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_8_bit_dec.sv
// Byte-serial AES-128 decryptor: 16-byte load, 10 key-expansion rounds, 10 inverse
// rounds, 16-byte output. Optional macro AES_DEC_KEY_CACHE_EN skips expansion on a repeated key.
module aes_8_bit_dec
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ct_in,
  input  logic [7:0] key_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] pt_out,
  output logic       out_valid,
  output logic       busy,
  output aes_state_e dbg_state
);

  // Handshake: a byte pair is taken on any ena edge with in_valid && in_ready;
  // out_valid has no ready, so the consumer must take every byte as it appears.
  localparam logic [3:0] LAST_RND = 4'(NR - 1);

  aes_state_e   r_fsm, w_fsm_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_state, r_key;
  logic [7:0]   r_pt;
  logic         r_out_valid;
  logic [127:0] w_key_full, w_key_next, w_add, w_ark, w_round, w_cache_rk;
  logic [7:0]   w_rcon;
  logic         w_last, w_inv, w_hit;

  assign w_last     = (r_cnt == LAST_RND);
  assign w_inv      = (r_fsm == ST_DEC);
  assign w_key_full = {r_key[119:0], key_in};
  assign w_rcon     = w_inv ? RCON[LAST_RND - r_cnt] : RCON[r_cnt];

  aes_key_step u_key_step (
    .i_key  (r_key),
    .i_rcon (w_rcon),
    .i_inv  (w_inv),
    .o_key  (w_key_next)
  );

  // The first inverse round also folds in round key 10.
  assign w_add   = (r_cnt == 4'd0) ? (r_state ^ r_key) : r_state;
  assign w_ark   = inv_sub_bytes(inv_shift_rows(w_add)) ^ w_key_next;
  assign w_round = w_last ? w_ark : inv_mix_columns(w_ark);

`ifdef AES_DEC_KEY_CACHE_EN
  logic         r_cache_vld;
  logic [127:0] r_cache_key, r_cache_rk;

  assign w_hit      = r_cache_vld && (w_key_full == r_cache_key);
  assign w_cache_rk = r_cache_rk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= '0;
      r_cache_rk  <= '0;
    end else if (ena) begin
      if (r_fsm == ST_LOAD && in_valid && r_cnt == 4'd15 && !w_hit) begin
        r_cache_key <= w_key_full;
        r_cache_vld <= 1'b0;
      end
      if (r_fsm == ST_KEYEXP && w_last) begin
        r_cache_rk  <= w_key_next;
        r_cache_vld <= 1'b1;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_cache_rk = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_LOAD;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (ena) begin
      unique case (r_fsm)
        ST_LOAD:   if (in_valid && r_cnt == 4'd15) w_fsm_nxt = w_hit ? ST_DEC : ST_KEYEXP;
        ST_KEYEXP: if (w_last) w_fsm_nxt = ST_DEC;
        ST_DEC:    if (w_last) w_fsm_nxt = ST_OUT;
        ST_OUT:    if (r_cnt == 4'd15) w_fsm_nxt = ST_LOAD;
        default:   w_fsm_nxt = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_state     <= '0;
      r_key       <= '0;
      r_pt        <= '0;
      r_out_valid <= 1'b0;
    end else if (ena) begin
      unique case (r_fsm)
        ST_LOAD: if (in_valid) begin
          r_state <= {r_state[119:0], ct_in};
          r_key   <= (r_cnt == 4'd15 && w_hit) ? w_cache_rk : w_key_full;
          r_cnt   <= r_cnt + 4'd1;
        end
        ST_KEYEXP: begin
          r_key <= w_key_next;
          r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
        ST_DEC: begin
          r_key <= w_key_next;
          r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
          if (w_last) begin
            r_state     <= {w_round[119:0], 8'h00};
            r_pt        <= w_round[127:120];
            r_out_valid <= 1'b1;
          end else begin
            r_state <= w_round;
          end
        end
        ST_OUT: begin
          if (r_cnt == 4'd15) begin
            r_out_valid <= 1'b0;
            r_pt        <= 8'h00;
            r_cnt       <= '0;
          end else begin
            r_pt    <= r_state[127:120];
            r_state <= {r_state[119:0], 8'h00};
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_fsm == ST_LOAD);
  assign busy      = (r_fsm != ST_LOAD);
  assign pt_out    = r_pt;
  assign out_valid = r_out_valid;
  assign dbg_state = r_fsm;

endmodule

// File: tb/tb_aes_8_bit_dec.sv
// Directed bench for aes_8_bit_dec using FIPS-197 vectors; compile with
// AES_DEC_KEY_CACHE_EN to expect the shortened repeated-key latency.
module tb_aes_8_bit_dec;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 10;
`else
  localparam int HIT_LAT = 20;
`endif

  logic       clk = 1'b0;
  logic       rst, ena, in_valid;
  logic [7:0] ct_in, key_in, pt_out;
  logic       in_ready, out_valid, busy;
  aes_state_e dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  aes_8_bit_dec #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .ct_in     (ct_in),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_out    (pt_out),
    .out_valid (out_valid),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_block(input logic [127:0] ct, input logic [127:0] key, input bit gaps);
    int g;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          in_valid = 1'b0;
          ct_in    = 8'($urandom);
          key_in   = 8'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      ct_in    = ct[127-8*i -: 8];
      key_in   = key[127-8*i -: 8];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] exp_pt, input bit gaps, input bit junk,
                           input bit drop_dec, input bit drop_out, input int exp_lat);
    int         edges;
    logic [127:0] got;
    logic       vld_ok, held_ok;
    logic [7:0] held;
    load_block(ct, key, gaps);
    check({tag, " busy_after_load"}, 128'({busy, in_ready}), 128'(2'b10));
    in_valid = junk;
    edges = 0;
    while (!out_valid && edges < 200) begin
      if (drop_dec && edges == 12) ena = 1'b0;
      if (drop_dec && edges == 17) ena = 1'b1;
      ct_in  = 8'($urandom);
      key_in = 8'($urandom);
      tick();
      edges++;
    end
    ena = 1'b1;
    check({tag, " latency"}, 128'(edges), 128'(exp_lat));
    got = '0;
    vld_ok = 1'b1;
    held_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      got = {got[119:0], pt_out};
      vld_ok = vld_ok & out_valid;
      if (drop_out && k == 5) begin
        held = pt_out;
        ena = 1'b0;
        repeat (5) begin
          tick();
          edges++;
          if (out_valid !== 1'b1 || pt_out !== held) held_ok = 1'b0;
        end
        ena = 1'b1;
      end
      ct_in  = 8'($urandom);
      key_in = 8'($urandom);
      tick();
      edges++;
    end
    in_valid = 1'b0;
    check({tag, " plaintext"}, got, exp_pt);
    check({tag, " out_valid_held"}, 128'(vld_ok), 128'(1'b1));
    if (drop_out) check({tag, " frozen_output"}, 128'(held_ok), 128'(1'b1));
    check({tag, " total_edges"}, 128'(edges), 128'(exp_lat + 16 + (drop_out ? 5 : 0)));
    check({tag, " back_to_load"}, 128'({in_ready, out_valid, busy}), 128'(3'b100));
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    in_valid = 1'b0;
    ct_in = 8'h00;
    key_in = 8'h00;
    tick();
    tick();
    check("reset pt_out", 128'(pt_out), 128'(8'h00));
    check("reset flags", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    check("reset state", 128'(dbg_state), 128'(ST_LOAD));
    rst = 1'b0;

    run_block("c1", C1_CT, C1_KEY, C1_PT, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    run_block("c1_repeat", C1_CT, C1_KEY, C1_PT, 1'b0, 1'b0, 1'b0, 1'b0, HIT_LAT);
    run_block("appb", B_CT, B_KEY, B_PT, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    run_block("c1_gaps_junk", C1_CT, C1_KEY, C1_PT, 1'b1, 1'b1, 1'b0, 1'b0, 20);

    // Abort mid-decrypt, then abort a partial load, then a clean run.
    load_block(C1_CT, C1_KEY, 1'b0);
    repeat (HIT_LAT - 5) tick();
    check("mid_dec state", 128'(dbg_state), 128'(ST_DEC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_reset flags", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    check("post_reset state", 128'(dbg_state), 128'(ST_LOAD));
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      ct_in    = B_CT[127-8*i -: 8];
      key_in   = B_KEY[127-8*i -: 8];
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_block("c1_after_reset", C1_CT, C1_KEY, C1_PT, 1'b0, 1'b0, 1'b0, 1'b0, 20);

    run_block("appb_ena_drop", B_CT, B_KEY, B_PT, 1'b0, 1'b0, 1'b1, 1'b1, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
